sequenciador_instrucoes: RTL and testbench
==========================================

Name: sequenciador_instrucoes

Overview:
- Instruction sequencer that reads the program memory `memoria`: drives the program counter `count`, captures the returned `insControle` (opcode) and `inX` (operand), and issues one-cycle control strobes to the datapath.
- Sits between the program ROM and the register/ALU datapath.
- Runs the program from address 0 until HALT, with a start/ready handshake to the ALU.

Parameters:
- W_PC, 4, program counter width (matches `count`).
- W_DATA, 4, operand width (matches `inX`).
- W_OP, 4, opcode width (matches `insControle`).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run the program from address 0
- count  out  W_PC  program counter to memory address input
- insControle  in  W_OP  opcode from memory (combinational read)
- inX  in  W_DATA  operand from memory
- dado  out  W_DATA  latched operand to datapath
- clr  out  1  clear-all-registers strobe
- ld_x  out  1  load `dado` into register X (strobe)
- ld_y  out  1  load `dado` into register Y (strobe)
- alu_op  out  1  0 = add, 1 = sub; held while ALU busy
- alu_start  out  1  one-cycle ALU request
- alu_pronto  in  1  ALU result valid/acknowledge
- busy  out  1  high from accepted start until HALT completes
- done  out  1  one-cycle pulse on HALT
- erro  out  1  sticky illegal-opcode flag (constant 0 without macro)

Behaviour:
- Single clock `clk`; reset is synchronous and active-high on `rst`.
- Reset values: state = OCIOSO, count = 0, dado = 0, IR = 0, alu_op = 0, erro = 0; all strobes, busy and done = 0.
- Opcodes:
  - 0 CLR
  - 1 LDX
  - 2 LDY
  - 3 ADD
  - 4 SUB
  - 5 HALT
  - 6..15 illegal
- States: OCIOSO, BUSCA, EXECUTA, ESPERA_ULA, FIM (plus ERRO under the macro).
- OCIOSO:
  - busy = 0.
  - If start = 1: count <= 0, go to BUSCA.
  - start is ignored in every other state.
- BUSCA (1 cycle):
  - count is stable, so memory output is valid.
  - On the clock edge, latch IR_op <= insControle, dado <= inX; go to EXECUTA.
- EXECUTA (1 cycle), strobe asserted during this cycle only:
  - CLR: clr = 1.
  - LDX: ld_x = 1.
  - LDY: ld_y = 1.
  - ADD/SUB: alu_start = 1, alu_op = IR_op == SUB; go to ESPERA_ULA.
  - HALT: go to FIM.
  - Illegal: treated as NOP.
  - CLR/LDX/LDY/illegal: count <= count + 1, then BUSCA.
- ESPERA_ULA:
  - Hold alu_op; alu_start = 0.
  - On alu_pronto = 1: count <= count + 1, then BUSCA. No timeout.
  - alu_pronto high in the same cycle as alu_start is not accepted; only ESPERA_ULA samples it.
- FIM (1 cycle): done = 1, busy = 0 next cycle, go to OCIOSO. count holds the HALT address.
- busy = 1 in BUSCA, EXECUTA, ESPERA_ULA and FIM.
- Latency: 2 cycles per non-ALU instruction; 2 + N cycles per ALU instruction, where N ≥ 1 is the number of ESPERA_ULA cycles.
- PC wrap: increment from 15 wraps to 0 (modulo 2^W_PC) and execution continues.
- Reset mid-operation: abort immediately to reset values; no strobe is emitted in the reset cycle.
- Strobes are mutually exclusive and never asserted outside EXECUTA.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in EXECUTA sets erro = 1 (sticky), emits no strobe and goes to ERRO.
  - ERRO: busy = 1, count frozen, held until rst.
  - done is never pulsed from ERRO.
- Undefined: illegal opcodes behave as NOP; erro is tied to 0.

Decomposition:
- Shared package `controle_pkg`:
  - opcode localparams OP_CLR..OP_HALT
  - state encoding typedef (3-bit)
  - W_PC/W_DATA/W_OP defaults
- Natural sub-module: `contador_programa` (PC register with clear, increment-enable and wrap). FSM and decode stay in the top module.

Test Plan:
- Program image [0:CLR/0, 1:LDX/3, 2:LDY/5, 3:ADD/0, 4:SUB/0, 5:HALT/0], ALU replies pronto 1 cycle after start:
  - clr at cycle 2.
  - ld_x with dado = 3 at cycle 4.
  - ld_y with dado = 5 at cycle 6.
  - alu_start with alu_op = 0, then alu_op = 1.
  - done once.
  - busy falls after FIM.
- ALU pronto delayed 5 cycles on ADD: sequencer holds in ESPERA_ULA with count = 3 and alu_op = 0 stable; no extra alu_start.
- Assert rst during ESPERA_ULA: next cycle count = 0, busy = 0, all strobes 0; a subsequent start reruns from address 0.
- Opcode 9 at address 1, macro undefined: no strobe, count advances to 2, erro = 0. Macro defined: erro = 1, count frozen at 1, done never pulses until rst.
- Program of 16 LDX with no HALT: count goes 15 -> 0 and ld_x keeps pulsing every 2 cycles.
- start pulsed while busy: ignored, program sequence unchanged.

Source files
------------

// File: rtl/controle_pkg.sv
// controle_pkg: default widths, opcode values and FSM state encoding shared by the sequencer.
package controle_pkg;
  localparam int DEF_W_PC = 4;
  localparam int DEF_W_DATA = 4;
  localparam int DEF_W_OP = 4;
  localparam logic [DEF_W_OP-1:0] OP_CLR = 4'd0;
  localparam logic [DEF_W_OP-1:0] OP_LDX = 4'd1;
  localparam logic [DEF_W_OP-1:0] OP_LDY = 4'd2;
  localparam logic [DEF_W_OP-1:0] OP_ADD = 4'd3;
  localparam logic [DEF_W_OP-1:0] OP_SUB = 4'd4;
  localparam logic [DEF_W_OP-1:0] OP_HALT = 4'd5;
  typedef enum logic [2:0] {OCIOSO, BUSCA, EXECUTA, ESPERA_ULA, FIM, ERRO} estado_t;
endpackage

// File: rtl/contador_programa.sv
// contador_programa: program counter with clear, increment enable and natural modulo-2^W wrap.
module contador_programa #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  always_ff @(posedge clk)
    if (rst || i_clr) o_count <= '0;
    else if (i_inc) o_count <= o_count + 1'b1;
endmodule

// File: rtl/sequenciador_instrucoes.sv
// sequenciador_instrucoes: fetch/execute sequencer driving control strobes and an ALU handshake.
// Define SEQ_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky ERRO state.
module sequenciador_instrucoes
  import controle_pkg::*;
#(
  parameter int W_PC = DEF_W_PC,
  parameter int W_DATA = DEF_W_DATA,
  parameter int W_OP = DEF_W_OP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [W_PC-1:0]   count,
  input  logic [W_OP-1:0]   insControle,
  input  logic [W_DATA-1:0] inX,
  output logic [W_DATA-1:0] dado,
  output logic              clr,
  output logic              ld_x,
  output logic              ld_y,
  output logic              alu_op,
  output logic              alu_start,
  input  logic              alu_pronto,
  output logic              busy,
  output logic              done,
  output logic              erro
);
  estado_t             r_state, w_next;
  logic [W_OP-1:0]     r_ir;
  logic [W_DATA-1:0]   r_dado;
  logic                r_alu_op;
  logic                w_pc_clr, w_pc_inc, w_exec, w_alu;
  contador_programa #(.W(W_PC)) u_pc (
    .clk(clk), .rst(rst), .i_clr(w_pc_clr), .i_inc(w_pc_inc), .o_count(count)
  );
  // strobes are gated by rst so the reset cycle never emits one
  assign w_exec = (r_state == EXECUTA) && !rst;
  assign w_alu = (r_ir == OP_ADD) || (r_ir == OP_SUB);
  assign clr = w_exec && (r_ir == OP_CLR);
  assign ld_x = w_exec && (r_ir == OP_LDX);
  assign ld_y = w_exec && (r_ir == OP_LDY);
  assign alu_start = w_exec && w_alu;
  assign alu_op = alu_start ? (r_ir == OP_SUB) : r_alu_op;
  assign done = (r_state == FIM) && !rst;
  assign busy = r_state != OCIOSO;
  assign dado = r_dado;
  always_comb begin
    w_next = r_state;
    w_pc_clr = 1'b0;
    w_pc_inc = 1'b0;
    case (r_state)
      OCIOSO: begin
        w_next = start ? BUSCA : OCIOSO;
        w_pc_clr = start;
      end
      BUSCA: w_next = EXECUTA;
      EXECUTA:
        if (w_alu) w_next = ESPERA_ULA;
        else if (r_ir == OP_HALT) w_next = FIM;
`ifdef SEQ_ILLEGAL_TRAP_EN
        else if (r_ir > OP_HALT) w_next = ERRO;
`endif
        else begin
          w_next = BUSCA;
          w_pc_inc = 1'b1;
        end
      ESPERA_ULA: begin
        w_next = alu_pronto ? BUSCA : ESPERA_ULA;
        w_pc_inc = alu_pronto;
      end
      FIM: w_next = OCIOSO;
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OCIOSO;
      r_ir <= '0;
      r_dado <= '0;
      r_alu_op <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == BUSCA) begin
        r_ir <= insControle;
        r_dado <= inX;
      end
      if (alu_start) r_alu_op <= r_ir == OP_SUB;
    end
  end
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic r_erro;
  always_ff @(posedge clk)
    if (rst) r_erro <= 1'b0;
    else if (w_exec && r_ir > OP_HALT) r_erro <= 1'b1;
  assign erro = r_erro;
`else
  assign erro = 1'b0;
`endif
endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// tb_sequenciador_instrucoes: scoreboard bench comparing strobe events against a cycle-level program model.
module tb_sequenciador_instrucoes;
  import controle_pkg::*;
  logic clk = 1'b0;
  logic rst, start, alu_pronto;
  logic [3:0] count, insControle, inX, dado;
  logic clr, ld_x, ld_y, alu_op, alu_start, busy, done, erro;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int alu_delay = 1;
  logic [3:0] mem_op [16];
  logic [3:0] mem_x [16];
  typedef struct {int c; logic [4:0] k; logic [3:0] d; logic op;} ev_t;
  ev_t exp_q [$];
  ev_t obs_q [$];

  sequenciador_instrucoes dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .insControle(insControle),
    .inX(inX), .dado(dado), .clr(clr), .ld_x(ld_x), .ld_y(ld_y), .alu_op(alu_op),
    .alu_start(alu_start), .alu_pronto(alu_pronto), .busy(busy), .done(done), .erro(erro)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign insControle = mem_op[count];
  assign inX = mem_x[count];

  always @(negedge clk) begin
    ev_t e;
    if ({clr, ld_x, ld_y, alu_start, done} != 5'b0) begin
      e.c = cyc; e.k = {clr, ld_x, ld_y, alu_start, done}; e.d = dado; e.op = alu_op;
      obs_q.push_back(e);
    end
  end

  initial begin
    alu_pronto = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_start) begin
        repeat (alu_delay) @(posedge clk);
        #1 alu_pronto = 1'b1;
        @(posedge clk);
        #1 alu_pronto = 1'b0;
      end
    end
  end

  function automatic void push(input int c, input logic [4:0] k, input logic [3:0] d, input logic o);
    ev_t e;
    e.c = c; e.k = k; e.d = d; e.op = o;
    exp_q.push_back(e);
  endfunction

  task automatic model(input int t0, input int lim);
    int pc, t;
    logic [3:0] op, x;
    pc = 0;
    t = t0 + 1;
    for (int n = 0; n < 64; n++) begin
      op = mem_op[pc];
      x = mem_x[pc];
      if (t + 1 > lim) break;
      if (op == OP_HALT) begin
        if (t + 2 <= lim) push(t + 2, 5'b00001, x, 1'b0);
        break;
      end
      if (op == OP_ADD || op == OP_SUB) begin
        push(t + 1, 5'b00010, x, op == OP_SUB);
        t = t + 2 + alu_delay;
      end else begin
        if (op == OP_CLR) push(t + 1, 5'b10000, x, 1'b0);
        else if (op == OP_LDX) push(t + 1, 5'b01000, x, 1'b0);
        else if (op == OP_LDY) push(t + 1, 5'b00100, x, 1'b0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        else break;
`endif
        t = t + 2;
      end
      pc = (pc + 1) % 16;
    end
  endtask

  task automatic compare(input string name);
    ev_t e, o;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s missing: got no event, expected cyc=%0d kind=%b dado=%0d", name, e.c, e.k, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.k !== e.k || o.d !== e.d || (e.k[1] && o.op !== e.op)) begin
          n_fail++;
          $display("FAIL %s event: got cyc=%0d kind=%b dado=%0d op=%b, expected cyc=%0d kind=%b dado=%0d op=%b",
                   name, o.c, o.k, o.d, o.op, e.c, e.k, e.d, e.op);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s extra: got %0d unexpected events (first cyc=%0d kind=%b), expected 0",
               name, obs_q.size(), obs_q[0].c, obs_q[0].k);
      obs_q.delete();
    end
  endtask

  task automatic at(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic prog_start(output int t0);
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy; i++) @(negedge clk);
    n_tests++;
    if (busy) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, lim);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 16; i++) begin mem_op[i] = OP_HALT; mem_x[i] = 4'd0; end
    mem_op[0] = OP_CLR; mem_op[1] = OP_LDX; mem_x[1] = 4'd3; mem_op[2] = OP_LDY; mem_x[2] = 4'd5;
    mem_op[3] = OP_ADD; mem_op[4] = OP_SUB; mem_op[5] = OP_HALT;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    load_prog1();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count", {4'd0, count}, 8'd0);
    chk("rst_dado", {4'd0, dado}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_erro", {7'd0, erro}, 8'd0);
    chk("rst_alu_op", {7'd0, alu_op}, 8'd0);
    chk("rst_strobes", {3'd0, clr, ld_x, ld_y, alu_start, done}, 8'd0);
    obs_q.delete();
  endtask

  task automatic test_program();
    int t0;
    load_prog1();
    alu_delay = 1;
    prog_start(t0);
    model(t0, t0 + 200);
    at(t0 + 15);
    chk("fim_done", {7'd0, done}, 8'd1);
    chk("fim_count", {4'd0, count}, 8'd5);
    at(t0 + 16);
    chk("after_fim_busy", {7'd0, busy}, 8'd0);
    wait_idle(50);
    compare("program");
  endtask

  task automatic test_alu_delay();
    int t0;
    load_prog1();
    alu_delay = 5;
    prog_start(t0);
    model(t0, t0 + 200);
    for (int c = t0 + 9; c <= t0 + 13; c++) begin
      at(c);
      chk("espera_count", {4'd0, count}, 8'd3);
      chk("espera_alu_op", {7'd0, alu_op}, 8'd0);
    end
    wait_idle(80);
    compare("alu_delay");
  endtask

  task automatic test_reset_mid();
    int t0;
    load_prog1();
    alu_delay = 4;
    prog_start(t0);
    model(t0, t0 + 9);
    go(t0 + 10);
    rst = 1'b1;
    go(t0 + 11);
    rst = 1'b0;
    at(t0 + 11);
    chk("rmid_count", {4'd0, count}, 8'd0);
    chk("rmid_busy", {7'd0, busy}, 8'd0);
    chk("rmid_strobes", {3'd0, clr, ld_x, ld_y, alu_start, done}, 8'd0);
    repeat (8) @(negedge clk);
    compare("reset_mid");
    alu_delay = 1;
    prog_start(t0);
    model(t0, t0 + 200);
    wait_idle(50);
    compare("rerun");
  endtask

  task automatic test_illegal();
    int t0;
    for (int i = 0; i < 16; i++) begin mem_op[i] = OP_HALT; mem_x[i] = 4'd0; end
    mem_op[0] = OP_CLR; mem_op[1] = 4'd9; mem_x[1] = 4'd7; mem_op[2] = OP_LDX; mem_x[2] = 4'd2;
    alu_delay = 1;
    prog_start(t0);
    model(t0, t0 + 15);
`ifdef SEQ_ILLEGAL_TRAP_EN
    at(t0 + 8);
    chk("trap_erro", {7'd0, erro}, 8'd1);
    chk("trap_count", {4'd0, count}, 8'd1);
    chk("trap_busy", {7'd0, busy}, 8'd1);
`else
    at(t0 + 4);
    chk("nop_erro", {7'd0, erro}, 8'd0);
    at(t0 + 5);
    chk("nop_count", {4'd0, count}, 8'd2);
`endif
    go(t0 + 16);
    rst = 1'b1;
    go(t0 + 17);
    rst = 1'b0;
    at(t0 + 17);
    chk("illegal_erro_cleared", {7'd0, erro}, 8'd0);
    compare("illegal");
  endtask

  task automatic test_wrap();
    int t0;
    for (int i = 0; i < 16; i++) begin mem_op[i] = OP_LDX; mem_x[i] = 4'(i); end
    prog_start(t0);
    model(t0, t0 + 40);
    at(t0 + 31);
    chk("wrap_count15", {4'd0, count}, 8'd15);
    at(t0 + 33);
    chk("wrap_count0", {4'd0, count}, 8'd0);
    go(t0 + 41);
    rst = 1'b1;
    go(t0 + 42);
    rst = 1'b0;
    compare("wrap");
  endtask

  task automatic test_back_to_back();
    int t0;
    load_prog1();
    alu_delay = 1;
    prog_start(t0);
    model(t0, t0 + 200);
    go(t0 + 5);
    start = 1'b1;
    go(t0 + 6);
    start = 1'b0;
    go(t0 + 11);
    start = 1'b1;
    go(t0 + 12);
    start = 1'b0;
    wait_idle(50);
    compare("start_busy");
  endtask

  initial begin
    test_reset();
    test_program();
    test_alu_delay();
    test_reset_mid();
    test_illegal();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
